// File: rtl/jump_pkg.sv
// jump_pkg - shared definitions for the jump game control core.
// Holds the 4-bit state codes (also decoded by the seven-segment stage,
// which spells "DEAD" for code 7), saturation limits for the score and
// charge counters, and the charge-to-distance conversion helper.
package jump_pkg;

  // Code 6 is deliberately left unused.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_READY  = 4'd1,
    ST_CHARGE = 4'd2,
    ST_JUMP   = 4'd3,
    ST_LAND   = 4'd4,
    ST_SCORE  = 4'd5,
    ST_DEAD   = 4'd7
  } state_t;

  localparam logic [9:0] SCORE_MAX  = 10'd1023;
  localparam logic [9:0] CHARGE_MAX = 10'd1023;

  // Scale the hold time down to a distance; clamp to the 8-bit range.
  function automatic logic [7:0] charge_to_dist(input logic [9:0] charge,
                                                input int        shift);
    logic [9:0] scaled;
    scaled = charge >> shift;
    return (scaled > 10'd255) ? 8'hFF : scaled[7:0];
  endfunction

endpackage

// File: rtl/jump_ctrl_btn_edge.sv
// btn_edge - registers the debounced button level and reports edges.
// Ports:
//   clk, rst  system clock, synchronous active-high reset
//   btn       debounced button level (1 = pressed)
//   rise      btn went 0 -> 1 (btn & ~btn_q)
//   fall      btn went 1 -> 0 (~btn & btn_q)
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise,
  output logic fall
);

  logic btn_q;

  // Previous-cycle copy of the button level.
  always_ff @(posedge clk) begin
    if (rst) btn_q <= 1'b0;
    else     btn_q <= btn;
  end

  assign rise = btn & ~btn_q;
  assign fall = ~btn & btn_q;

endmodule

// File: rtl/jump_ctrl.sv
// jump_ctrl - game-control core of the jump game.
// Measures the button hold time, converts it into a jump distance, judges
// the landing against the platform gap and keeps score / best score.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   tick       1 kHz single-cycle enable strobe
//   btn        debounced button level (1 = pressed)
//   gap        distance to next platform, valid with gap_valid
//   gap_valid  platform generator presents gap
//   gap_req    registered request for a new gap
//   score      current score (saturating, 10 bits)
//   best       highest score seen at any death
//   state      4-bit state code for the display
//   jump_dist  distance of the most recent jump
module jump_ctrl
  import jump_pkg::*;
#(
  parameter int DIST_SHIFT = 2,
  parameter int AIR_TICKS  = 300,
  parameter int TOL        = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn,
  input  logic [7:0] gap,
  input  logic       gap_valid,
  output logic       gap_req,
  output logic [9:0] score,
  output logic [9:0] best,
  output logic [3:0] state,
  output logic [7:0] jump_dist
);

  localparam logic [15:0] AIR_LAST = 16'(AIR_TICKS - 1);
  localparam logic [8:0]  TOL_9    = 9'(TOL);

  state_t      cur;
  logic [9:0]  charge;
  logic [15:0] air_cnt;
  logic [7:0]  gap_q;
  logic        scored;
  logic        rise;
  logic        fall;

  logic [8:0]  diff;
  logic [8:0]  mag;
  logic        land_ok;
  logic [10:0] score_sum;
  logic [9:0]  score_next;

  btn_edge u_btn_edge (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .rise (rise),
    .fall (fall)
  );

  // Landing judge: 9-bit difference so a short jump shows up as a negative
  // value whose magnitude is taken before comparing with the tolerance.
  assign diff    = {1'b0, jump_dist} - {1'b0, gap_q};
  assign mag     = diff[8] ? (9'd0 - diff) : diff;
  assign land_ok = (mag <= TOL_9);

  // A perfect landing is worth two points, a near one a single point.
  assign score_sum  = {1'b0, score} + ((jump_dist == gap_q) ? 11'd2 : 11'd1);
  assign score_next = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[9:0];

  assign state = cur;

  // Game FSM with its counters and registered outputs. gap_req is raised on
  // entry to IDLE/SCORE and dropped on the cycle after gap_valid is seen.
  // 'scored' makes the SCORE increment happen once while waiting for a gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur       <= ST_IDLE;
      score     <= 10'd0;
      best      <= 10'd0;
      jump_dist <= 8'd0;
      gap_req   <= 1'b0;
      charge    <= 10'd0;
      air_cnt   <= 16'd0;
      gap_q     <= 8'd0;
      scored    <= 1'b0;
    end else begin
      case (cur)
        ST_IDLE: begin
          score <= 10'd0;
          if (!gap_req) begin
            gap_req <= 1'b1;
          end else if (gap_valid) begin
            gap_q   <= gap;
            gap_req <= 1'b0;
            cur     <= ST_READY;
          end
        end

        ST_READY: begin
          if (rise) begin
            charge <= 10'd0;
            cur    <= ST_CHARGE;
          end
        end

        ST_CHARGE: begin
          // A release always wins over a coincident tick.
          if (fall) begin
            jump_dist <= charge_to_dist(charge, DIST_SHIFT);
            air_cnt   <= 16'd0;
            cur       <= ST_JUMP;
          end else if (tick && charge != CHARGE_MAX) begin
            charge <= charge + 10'd1;
          end
        end

        ST_JUMP: begin
          if (tick) begin
            if (air_cnt == AIR_LAST) begin
              air_cnt <= 16'd0;
              cur     <= ST_LAND;
            end else begin
              air_cnt <= air_cnt + 16'd1;
            end
          end
        end

        ST_LAND: begin
          if (land_ok) begin
            gap_req <= 1'b1;
            cur     <= ST_SCORE;
          end else begin
            cur <= ST_DEAD;
          end
        end

        ST_SCORE: begin
          if (!scored) begin
            score  <= score_next;
            scored <= 1'b1;
          end
          if (gap_req && gap_valid) begin
            gap_q   <= gap;
            gap_req <= 1'b0;
            scored  <= 1'b0;
            cur     <= ST_READY;
          end
        end

        ST_DEAD: begin
          if (score > best) best <= score;
          if (rise) begin
            score <= 10'd0;
            cur   <= ST_IDLE;
          end
        end

        default: cur <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/jump_ctrl.md
# jump_ctrl

Game-control core for the jump game. It measures how long the button is held, converts the hold time into a jump distance, and judges the landing against the gap supplied by the platform generator. It maintains the 10-bit score and the 4-bit game state that feed the seven-segment display stage directly. The display shows the score as hex digits and the state code, and spells "DEAD" whenever the state equals 7.

## Interface
Parameters:
- DIST_SHIFT, default 2: jump_dist = charge >> DIST_SHIFT.
- AIR_TICKS, default 300: airtime, counted in ticks, spent in JUMP.
- TOL, default 3: maximum |jump_dist − gap| that still counts as a landing.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- tick  in  1  1 kHz single-cycle enable strobe.
- btn  in  1  debounced button level; 1 = pressed.
- gap  in  8  distance to the next platform; valid with gap_valid.
- gap_valid  in  1  platform generator presents gap.
- gap_req  out  1  request for a new gap.
- score  out  10  current score.
- best  out  10  highest score at any death.
- state  out  4  state code; consumed by the display.
- jump_dist  out  8  distance of the most recent jump.

## Operation
Button edges:
- btn is registered each cycle into btn_q.
- rise = btn & ~btn_q; fall = ~btn & btn_q.

State codes:
- IDLE=0, READY=1, CHARGE=2, JUMP=3, LAND=4, SCORE=5, DEAD=7.
- Code 6 is unused. If ever reached, the next state is IDLE.

Transitions:
- IDLE: clear score to 0 on entry; assert gap_req; on gap_req & gap_valid, latch gap and go to READY.
- READY: on rise, clear charge and go to CHARGE.
- CHARGE: on each tick, charge++ (10-bit, saturating at 1023). On fall, load jump_dist = charge >> DIST_SHIFT (truncated to 8 bits, saturating at 255) and go to JUMP.
  - If fall and tick coincide, fall wins and that tick is not counted.
- JUMP: count AIR_TICKS ticks, then go to LAND. btn is ignored.
- LAND: one cycle. If |jump_dist − gap| ≤ TOL, go to SCORE; otherwise go to DEAD. Compute the difference at 9 bits, unsigned magnitude.
- SCORE: score += 2 if jump_dist == gap, else += 1, saturating at 1023. Then assert gap_req, latch the new gap on the handshake, and go to READY.
- DEAD: on entry, best ← max(best, score). Score holds its value while in DEAD. On rise, go to IDLE.

gap_req handshake:
- gap_req is registered. It rises on entry to IDLE or SCORE and stays high until the first cycle in which gap_valid = 1.
- gap is sampled in that cycle, and gap_req is 0 from the next cycle.
- If gap_valid is already high when gap_req rises, the transfer completes on that cycle.

## Timing
- Reset values: state=0, score=0, best=0, jump_dist=0, gap_req=0, charge=0, air counter=0, latched gap=0.
- The first cycle after reset is IDLE with gap_req rising to 1 at the next edge.
- All outputs are registered. state changes one cycle after the qualifying event (edge, tick, or handshake).
- score updates one cycle after entering SCORE. best updates one cycle after entering DEAD.
- rise and fall are detected with one cycle of latency behind btn.
- Reset asserted mid-operation (for example during JUMP or while waiting on gap_req) forces every reset value on the next edge; any pending request is dropped.

## Structure
- Shared package jump_pkg holds:
  - the state encodings as a 4-bit enum/localparams, including DEAD=4'd7 so the display's dead check agrees;
  - SCORE_MAX=10'd1023;
  - CHARGE_MAX=10'd1023.
- One sub-module, btn_edge (registers btn and outputs rise/fall), is instantiated once.
- Everything else lives in jump_ctrl: the FSM, the saturating counters, and the judge.

## Test plan
- **Reset:** assert rst for 3 cycles → all outputs 0 and state=0; gap_req=1 one cycle after release. Drive gap=20 with gap_valid → state=1.
- **Perfect landing:** gap=20, hold btn for 80 ticks → jump_dist=20; after 300 ticks state passes 3→4→5; score 0→2; gap_req pulses; state=1.
- **Within tolerance:** gap=20, hold 92 ticks → jump_dist=23; score +1. Repeat with a 68-tick hold → jump_dist=17; score +1.
- **Death:**
  - With score=3, gap=20, hold 100 ticks → jump_dist=25 → state=7, best=3, score holds at 3.
  - Press btn → state=0, score=0, best=3.
- **Saturation and priority:**
  - Hold btn 2000 ticks → charge=1023, jump_dist=255.
  - Release in the same cycle as a tick with charge=79 → jump_dist=19, not 20.
- **Reset mid-JUMP:** assert rst 150 ticks into the airtime → state=0, score=0, best=0, gap_req=0, then normal restart.
